// File: rtl/sint_seq_mul_if.sv
// Operand and product handshake bundle for the sequential signed multiplier.
// The master drives operands and consumes the product; the slave is the multiplier.
interface sint_seq_mul_if #(
    parameter int width = 7
);
    logic [width-1:0]   I0;
    logic [width-1:0]   I1;
    logic               I_valid;
    logic               I_ready;
    logic [2*width-1:0] O;
    logic               O_valid;
    logic               O_ready;

    modport master (
        output I0, I1, I_valid, O_ready,
        input  I_ready, O, O_valid
    );

    modport slave (
        input  I0, I1, I_valid, O_ready,
        output I_ready, O, O_valid
    );
endinterface

// File: rtl/sint_seq_mul.sv
// Sequential two's-complement multiplier: shift-add on operand magnitudes over
// width+1 cycles, then sign correction into a 2*width-bit registered product.
module sint_seq_mul #(
    parameter int width = 7
) (
    input  logic          CLK,
    input  logic          RESET,
    sint_seq_mul_if.slave bus,
    output logic [1:0]    dbg_state
);
    // Handshake: a transfer happens on a rising CLK edge where valid and ready
    // are both high. I_ready is high only in IDLE, O_valid only in DONE, and
    // O is stable while O_valid is high and O_ready is low.

    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [width:0]     mcand;
    logic [width:0]     mplier;
    logic [2*width:0]   acc;
    logic [CW-1:0]      count;
    logic               sign;
    logic [2*width-1:0] prod;

    logic [width:0]     i0_ext;
    logic [width:0]     i1_ext;
    logic [width:0]     i0_mag;
    logic [width:0]     i1_mag;
    logic [2*width:0]   addend;
    logic [2*width:0]   acc_sum;
    logic [2*width-1:0] acc_signed;
    logic               accept;
    logic               last_iter;

    // Magnitudes are one bit wider so the most-negative operand stays positive.
    always_comb begin
        i0_ext     = {bus.I0[width-1], bus.I0};
        i1_ext     = {bus.I1[width-1], bus.I1};
        i0_mag     = i0_ext[width] ? -i0_ext : i0_ext;
        i1_mag     = i1_ext[width] ? -i1_ext : i1_ext;
        addend     = {{width{1'b0}}, mcand} << count;
        acc_sum    = mplier[0] ? acc + addend : acc;
        acc_signed = sign ? -acc_sum[2*width-1:0] : acc_sum[2*width-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last_iter   = 1'b0;
        bus.I_ready = 1'b0;
        bus.O_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.I_ready = 1'b1;
                if (bus.I_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (count == LAST) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.O_valid = 1'b1;
                if (bus.O_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            sign   <= 1'b0;
            prod   <= '0;
        end else if (accept) begin
            sign   <= bus.I0[width-1] ^ bus.I1[width-1];
            mcand  <= i0_mag;
            mplier <= i1_mag;
            acc    <= '0;
            count  <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_sum;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            // Negating a zero magnitude yields zero, so no negative-zero case.
            if (last_iter) begin
                prod <= acc_signed;
            end
        end
    end

    assign bus.O     = prod;
    assign dbg_state = state;
endmodule

// File: tb/tb_sint_seq_mul.sv
// Scoreboard bench for sint_seq_mul: drivers push expected products and accept
// cycles into queues, a negedge monitor pops and compares on each output transfer.
module tb_sint_seq_mul;
    localparam int W = 7;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    sint_seq_mul_if #(.width(W)) bus ();

    sint_seq_mul #(.width(W)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    logic [2*W-1:0] exp_q[$];
    int             lat_q[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic           prev_valid = 1'b0;
    bit             rand_stall = 1'b0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*W-1:0];
    endfunction

    // driver: call just after a rising edge; returns just after the accept edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] e, input bit hold, output int acc_cyc);
        int n;
        n = 0;
        bus.I0      = a;
        bus.I1      = b;
        bus.I_valid = 1'b1;
        @(negedge clk);
        while (!bus.I_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.I_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: I_ready stayed 0 for %0d cycles, required 1", n);
            acc_cyc = -1;
            bus.I_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        exp_q.push_back(e);
        lat_q.push_back(cyc);
        #1;
        if (!hold) bus.I_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.O_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus.O_valid), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // random consumer stalls
    always @(posedge clk) begin
        if (rand_stall) begin
            #1;
            bus.O_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.O_valid && !prev_valid) begin
                if (lat_q.size() != 0) begin
                    check("latency", 32'(cyc - lat_q.pop_front()), 32'd8);
                end
            end
            if (bus.O_valid && bus.O_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got O=0x%0h with empty expected queue", bus.O);
                end else begin
                    check("product", 32'(bus.O), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_valid = bus.O_valid;
    end

    initial begin
        int t0, t1, t2;
        logic [W-1:0] a, b;
        rst         = 1'b1;
        bus.I0      = '0;
        bus.I1      = '0;
        bus.I_valid = 1'b0;
        bus.O_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_i_ready", 32'(bus.I_ready), 32'd1);
        check("reset_o_valid", 32'(bus.O_valid), 32'd0);
        check("reset_o", 32'(bus.O), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        // basic 3*5
        @(posedge clk); #1;
        bus.O_ready = 1'b1;
        send(7'd3, 7'd5, 14'h000F, 1'b0, t0);
        wait_valid("basic_valid");
        @(negedge clk);
        check("basic_i_ready_back", 32'(bus.I_ready), 32'd1);
        check("basic_o_valid_drop", 32'(bus.O_valid), 32'd0);
        @(posedge clk); #1;

        // extremes
        send(7'h40, 7'h40, 14'h1000, 1'b0, t0);
        send(7'h40, 7'h3F, 14'h3040, 1'b0, t0);
        send(7'h07, 7'h7F, 14'h3FF9, 1'b0, t0);
        send(7'h00, 7'h7B, 14'h0000, 1'b0, t0);
        send(7'h3F, 7'h3F, 14'h0F81, 1'b0, t0);
        wait_drain("extremes_drain");

        // backpressure
        bus.O_ready = 1'b0;
        send(7'd3, 7'd5, 14'h000F, 1'b0, t0);
        wait_valid("bp_valid");
        for (int i = 0; i < 6; i++) begin
            check("bp_o_hold", 32'(bus.O), 32'h000F);
            check("bp_valid_hold", 32'(bus.O_valid), 32'd1);
            check("bp_i_ready_low", 32'(bus.I_ready), 32'd0);
            @(posedge clk); #1;
            if (i == 1) begin
                bus.I0      = 7'd9;
                bus.I_valid = 1'b1;
            end else begin
                bus.I_valid = 1'b0;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.O_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_drop", 32'(bus.O_valid), 32'd0);
        check("bp_o_kept", 32'(bus.O), 32'h000F);
        check("bp_i_ready_back", 32'(bus.I_ready), 32'd1);
        @(posedge clk); #1;

        // reset mid-operation
        send(7'd3, 7'd5, 14'h000F, 1'b0, t0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check("midrst_i_ready", 32'(bus.I_ready), 32'd1);
        check("midrst_o_valid", 32'(bus.O_valid), 32'd0);
        check("midrst_o", 32'(bus.O), 32'd0);
        repeat (15) @(negedge clk);
        check("midrst_no_pulse", 32'(bus.O_valid), 32'd0);
        @(posedge clk); #1;
        send(7'd2, 7'd2, 14'h0004, 1'b0, t0);
        wait_drain("midrst_drain");

        // back-to-back stream
        send(7'h01, 7'h01, 14'h0001, 1'b1, t0);
        send(7'h7E, 7'h03, 14'h3FFA, 1'b1, t1);
        send(7'h05, 7'h7B, 14'h3FE7, 1'b0, t2);
        check("stream_ii_1", 32'(t1 - t0), 32'd10);
        check("stream_ii_2", 32'(t2 - t1), 32'd10);
        wait_drain("stream_drain");

        // random operands with consumer stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom_range(0, 127));
            b = W'($urandom_range(0, 127));
            send(a, b, golden(a, b), 1'b0, t0);
        end
        wait_drain("random_drain");
        rand_stall = 1'b0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
